// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipeline_pkg;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned DefaultPcW   = 16;

  // All-zero payload is the NOP encoding used for bubbles.
  localparam logic [DefaultDataW-1:0] BUBBLE_DATA = '0;

  typedef enum logic {
    RUN,
    STALL
  } stageState_t;

endpackage

// File: rtl/stall_counter.sv
// Multi-cycle stall counter: loads a request, counts down, merges overlapping requests by max.
module stall_counter
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [CNT_W-1:0] cycles,
  input  logic             clear,
  output logic             active,
  output logic [CNT_W-1:0] remaining
);

  stageState_t      stateQ;
  logic [CNT_W-1:0] cntQ;
  logic [CNT_W-1:0] decCnt;
  logic [CNT_W-1:0] mergedCnt;

  always_comb begin
    decCnt    = (cntQ == '0) ? '0 : cntQ - CNT_W'(1);
    mergedCnt = (req && (cycles > decCnt)) ? cycles : decCnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cntQ   <= '0;
      stateQ <= RUN;
    end else if (clear) begin
      cntQ   <= '0;
      stateQ <= RUN;
    end else begin
      unique case (stateQ)
        RUN: begin
          if (req && (cycles != '0)) begin
            cntQ   <= cycles;
            stateQ <= STALL;
          end
        end
        STALL: begin
          cntQ   <= mergedCnt;
          stateQ <= (mergedCnt == '0) ? RUN : STALL;
        end
      endcase
    end
  end

  assign active    = (stateQ == STALL);
  assign remaining = cntQ;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Generic pipeline stage register with multi-cycle stall, flush bubble and optional sticky halt.
module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned PC_W        = DefaultPcW,
  parameter int unsigned CNT_W       = 2,
  parameter bit          STICKY_HALT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic              halt_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              stall_req_in,
  input  logic [CNT_W-1:0]  stall_cycles_in,
  output logic              valid_out,
  output logic              halt_out,
  output logic [DATA_W-1:0] data_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              flush_out,
  output logic              stall_out,
  output logic [CNT_W-1:0]  stall_remaining
);

  localparam logic [DATA_W-1:0] BubbleData = DATA_W'(BUBBLE_DATA);

  logic              validQ;
  logic              haltQ;
  logic [DATA_W-1:0] dataQ;
  logic [PC_W-1:0]   pcQ;
  logic              flushQ;
  logic              stallActive;
  logic              load;
  logic              haltNext;

  stall_counter #(
    .CNT_W(CNT_W)
  ) uStallCounter (
    .clk      (clk),
    .rst      (rst),
    .req      (stall_req_in),
    .cycles   (stall_cycles_in),
    .clear    (flush_in),
    .active   (stallActive),
    .remaining(stall_remaining)
  );

  assign load     = we & ~stallActive & ~flush_in;
  assign haltNext = STICKY_HALT ? (haltQ | halt_in) : halt_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      validQ <= 1'b0;
      haltQ  <= 1'b0;
      dataQ  <= '0;
      pcQ    <= '0;
      flushQ <= 1'b0;
    end else begin
      flushQ <= flush_in;
      if (flush_in) begin
        validQ <= 1'b0;
        haltQ  <= 1'b0;
        dataQ  <= BubbleData;
        pcQ    <= '0;
      end else if (load) begin
        validQ <= valid_in;
        haltQ  <= haltNext;
        dataQ  <= data_in;
        pcQ    <= pc_in;
      end
    end
  end

  assign valid_out = validQ;
  assign halt_out  = haltQ;
  assign data_out  = dataQ;
  assign pc_out    = pcQ;
  assign flush_out = flushQ;
  assign stall_out = stallActive;

endmodule
